// File: rtl/mult_div_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit_if
// Description : E-stage bundle between the pipeline and the multiply/divide
//               unit.
//                 start  pipeline -> unit  valid md-class op in E this cycle
//                 op     pipeline -> unit  0 MULT,1 MULTU,2 DIV,3 DIVU,
//                                          4 MTHI,5 MTLO,6-7 no-op
//                 a, b   pipeline -> unit  forwarded rs / rt values
//                 busy   unit -> pipeline  op in flight, HI/LO not committed
//                 hi, lo unit -> pipeline  architectural HI / LO
// Revision    : 1.0 - initial release
// ============================================================================
interface mult_div_unit_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (output start, op, a, b, input  busy, hi, lo);
   modport slave  (input  start, op, a, b, output busy, hi, lo);
endinterface
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Multi-cycle multiply/divide unit holding architectural HI/LO.
//               The result is computed at the accept edge into shadow
//               registers; busy then stays high for MULT_CYCLES/DIV_CYCLES
//               cycles and the final decrement commits shadow to HI/LO.
//               Ports:
//                 clk   system clock, rising edge
//                 reset synchronous, active-high
//                 md    slave side of mult_div_unit_if (start/op/a/b in,
//                       busy/hi/lo out, all outputs registered)
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  wire logic       clk,
   input  wire logic       reset,
   mult_div_unit_if.slave  md
);

   localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int c_CW         = $clog2(c_MAX_CYCLES + 1);

   localparam logic [c_CW-1:0] c_MULT_CNT = c_CW'(MULT_CYCLES);
   localparam logic [c_CW-1:0] c_DIV_CNT  = c_CW'(DIV_CYCLES);
   localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

   localparam logic [2:0] c_OP_MULT  = 3'd0;
   localparam logic [2:0] c_OP_MULTU = 3'd1;
   localparam logic [2:0] c_OP_DIV   = 3'd2;
   localparam logic [2:0] c_OP_DIVU  = 3'd3;
   localparam logic [2:0] c_OP_MTHI  = 3'd4;
   localparam logic [2:0] c_OP_MTLO  = 3'd5;

   logic [c_CW-1:0] r_cnt;
   logic            r_busy;
   logic            r_commit;
   logic [31:0]     r_sh_hi;
   logic [31:0]     r_sh_lo;
   logic [31:0]     r_hi;
   logic [31:0]     r_lo;

   // Even opcodes (MULT, DIV) are the signed variants.
   logic        w_signed;
   logic [63:0] w_ext_a;
   logic [63:0] w_ext_b;
   logic [63:0] w_prod;
   logic        w_a_neg;
   logic        w_b_neg;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [31:0] w_divisor;
   logic [31:0] w_q_mag;
   logic [31:0] w_r_mag;
   logic [31:0] w_quot;
   logic [31:0] w_rem;

   assign w_signed = ~md.op[0];

   // Extend to 64 bits first so the low 64 bits of the product are exact
   // for both signed and unsigned operands.
   assign w_ext_a = {{32{w_signed & md.a[31]}}, md.a};
   assign w_ext_b = {{32{w_signed & md.b[31]}}, md.b};
   assign w_prod  = w_ext_a * w_ext_b;

   // Signed divide is done on magnitudes and the signs restored afterwards:
   // quotient truncates toward zero, remainder follows the dividend.
   // 0x80000000 has magnitude 0x80000000 as unsigned, so -2^31 / -1 wraps
   // to 0x80000000 with remainder 0 without any special case.
   assign w_a_neg   = w_signed & md.a[31];
   assign w_b_neg   = w_signed & md.b[31];
   assign w_a_mag   = w_a_neg ? (32'd0 - md.a) : md.a;
   assign w_b_mag   = w_b_neg ? (32'd0 - md.b) : md.b;
   // A zero divisor is replaced so the divider never yields X; that result
   // is never committed.
   assign w_divisor = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
   assign w_q_mag   = w_a_mag / w_divisor;
   assign w_r_mag   = w_a_mag % w_divisor;
   assign w_quot    = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
   assign w_rem     = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_commit <= 1'b0;
         r_sh_hi  <= '0;
         r_sh_lo  <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else if (r_cnt != '0) begin
         // In flight: any start is ignored here.
         r_cnt <= r_cnt - c_CNT_ONE;
         if (r_cnt == c_CNT_ONE) begin
            r_busy <= 1'b0;
            if (r_commit) begin
               r_hi <= r_sh_hi;
               r_lo <= r_sh_lo;
            end
         end
      end else if (md.start) begin
         case (md.op)
            c_OP_MULT, c_OP_MULTU: begin
               r_sh_hi  <= w_prod[63:32];
               r_sh_lo  <= w_prod[31:0];
               r_cnt    <= c_MULT_CNT;
               r_busy   <= 1'b1;
               r_commit <= 1'b1;
            end
            c_OP_DIV, c_OP_DIVU: begin
               r_sh_hi  <= w_rem;
               r_sh_lo  <= w_quot;
               r_cnt    <= c_DIV_CNT;
               r_busy   <= 1'b1;
               r_commit <= (md.b != 32'd0);
            end
            c_OP_MTHI: r_hi <= md.a;
            c_OP_MTLO: r_lo <= md.a;
            default:   ;
         endcase
      end
   end

   assign md.busy = r_busy;
   assign md.hi   = r_hi;
   assign md.lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Directed self-checking bench for mult_div_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   mult_div_unit_if md_if ();

   mult_div_unit #(
      .MULT_CYCLES (5),
      .DIV_CYCLES  (10)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .md    (md_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Single-cycle start pulse; the edge inside is the accept edge.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      md_if.start = 1'b1;
      md_if.op    = op;
      md_if.a     = a;
      md_if.b     = b;
      tick();
      md_if.start = 1'b0;
      md_if.op    = 3'd7;
   endtask

   // Count cycles with busy high after the accept edge (bounded).
   task automatic count_busy(output int cnt);
      cnt = 0;
      while (md_if.busy === 1'b1 && cnt < 64) begin
         cnt++;
         tick();
      end
   endtask

   initial begin
      int cnt;
      n_cmp = 0;
      n_err = 0;
      md_if.start = 1'b0;
      md_if.op    = 3'd7;
      md_if.a     = '0;
      md_if.b     = '0;

      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      check("reset_busy", {31'd0, md_if.busy}, 32'd0);
      check("reset_hi", md_if.hi, 32'd0);
      check("reset_lo", md_if.lo, 32'd0);

      // MULT -2 * 3 = -6
      issue(3'd0, 32'hFFFF_FFFE, 32'd3);
      check("mult_hi_held", md_if.hi, 32'd0);
      count_busy(cnt);
      check("mult_busy_cycles", cnt, 32'd5);
      check("mult_hi", md_if.hi, 32'hFFFF_FFFF);
      check("mult_lo", md_if.lo, 32'hFFFF_FFFA);

      // MULTU 0xFFFFFFFF^2 = 0xFFFFFFFE_00000001
      issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      count_busy(cnt);
      check("multu_busy_cycles", cnt, 32'd5);
      check("multu_hi", md_if.hi, 32'hFFFF_FFFE);
      check("multu_lo", md_if.lo, 32'h0000_0001);

      // MULT -2^31 * -2^31 = 2^62
      issue(3'd0, 32'h8000_0000, 32'h8000_0000);
      count_busy(cnt);
      check("mult_min_hi", md_if.hi, 32'h4000_0000);
      check("mult_min_lo", md_if.lo, 32'h0000_0000);

      // DIV -7 / 2 -> q=-3, r=-1
      issue(3'd2, 32'hFFFF_FFF9, 32'd2);
      check("div_lo_held", md_if.lo, 32'h0000_0000);
      count_busy(cnt);
      check("div_busy_cycles", cnt, 32'd10);
      check("div_lo", md_if.lo, 32'hFFFF_FFFD);
      check("div_hi", md_if.hi, 32'hFFFF_FFFF);

      // DIVU 7 / 2 -> q=3, r=1
      issue(3'd3, 32'd7, 32'd2);
      count_busy(cnt);
      check("divu_lo", md_if.lo, 32'd3);
      check("divu_hi", md_if.hi, 32'd1);

      // DIV 7 / -2 -> q=-3, r=1
      issue(3'd2, 32'd7, 32'hFFFF_FFFE);
      count_busy(cnt);
      check("div_negb_lo", md_if.lo, 32'hFFFF_FFFD);
      check("div_negb_hi", md_if.hi, 32'd1);

      // DIV overflow case
      issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      count_busy(cnt);
      check("div_ovf_lo", md_if.lo, 32'h8000_0000);
      check("div_ovf_hi", md_if.hi, 32'd0);

      // MTHI / MTLO then divide by zero
      issue(3'd4, 32'h0000_1234, 32'd0);
      check("mthi_busy", {31'd0, md_if.busy}, 32'd0);
      check("mthi_hi", md_if.hi, 32'h0000_1234);
      issue(3'd5, 32'h0000_5678, 32'd0);
      check("mtlo_lo", md_if.lo, 32'h0000_5678);
      check("mtlo_hi_kept", md_if.hi, 32'h0000_1234);
      issue(3'd2, 32'd99, 32'd0);
      count_busy(cnt);
      check("divz_busy_cycles", cnt, 32'd10);
      check("divz_hi", md_if.hi, 32'h0000_1234);
      check("divz_lo", md_if.lo, 32'h0000_5678);

      // No-op opcode with start
      issue(3'd6, 32'hDEAD_BEEF, 32'd5);
      check("nop_busy", {31'd0, md_if.busy}, 32'd0);
      check("nop_hi", md_if.hi, 32'h0000_1234);
      check("nop_lo", md_if.lo, 32'h0000_5678);

      // DIVU 100 / 7 with a MULT 2*2 presented mid-flight (must be ignored)
      issue(3'd3, 32'd100, 32'd7);
      cnt = 0;
      while (md_if.busy === 1'b1 && cnt < 64) begin
         cnt++;
         if (cnt == 3) begin
            md_if.start = 1'b1;
            md_if.op    = 3'd0;
            md_if.a     = 32'd2;
            md_if.b     = 32'd2;
         end else begin
            md_if.start = 1'b0;
         end
         tick();
      end
      md_if.start = 1'b0;
      check("ign_busy_cycles", cnt, 32'd10);
      check("ign_lo", md_if.lo, 32'd14);
      check("ign_hi", md_if.hi, 32'd2);
      tick();
      check("ign_no_restart", {31'd0, md_if.busy}, 32'd0);

      // MTHI 0xCAFEF00D
      issue(3'd4, 32'hCAFE_F00D, 32'd0);
      check("mthi2_busy", {31'd0, md_if.busy}, 32'd0);
      check("mthi2_hi", md_if.hi, 32'hCAFE_F00D);
      check("mthi2_lo_kept", md_if.lo, 32'd14);

      // Reset on busy cycle 3 of a MULT
      issue(3'd0, 32'd3, 32'd4);
      tick();
      tick();
      check("rst_mid_busy_before", {31'd0, md_if.busy}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_mid_busy", {31'd0, md_if.busy}, 32'd0);
      check("rst_mid_hi", md_if.hi, 32'd0);
      check("rst_mid_lo", md_if.lo, 32'd0);
      for (int i = 0; i < 8; i++) tick();
      check("rst_late_busy", {31'd0, md_if.busy}, 32'd0);
      check("rst_late_hi", md_if.hi, 32'd0);
      check("rst_late_lo", md_if.lo, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
